// File: rtl/uart_tx_axis_if.sv
// AXI-Stream style word channel feeding the UART transmitter.
// The master drives data/valid and the slave answers with ready.
interface uart_tx_axis_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/uart_tx_axis.sv
// UART transmitter: one stream word per frame, sent as a start bit, LSB-first data bits, then stop bit(s).
// The next word can be taken on the final stop-bit cycle, so frames run back-to-back with no idle gap.
module uart_tx_axis #(
  parameter int BAUD_DIVIDER = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_axis_if.slave  saxis,
  output logic           txd,
  output logic           busy
);
  localparam int BW = $clog2(BAUD_DIVIDER);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIVIDER - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [BW-1:0]        baud_q;
  logic [CW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 txd_q;
  logic                 busy_q;

  logic baud_end, ready, fire;

  assign baud_end = (baud_q == BAUD_LAST);
  assign ready    = (state_q == IDLE) ||
                    ((state_q == STOP) && (bit_q == STOP_LAST) && baud_end);
  // Gating with reset_n keeps ready low while reset is held even though state already reads IDLE.
  assign saxis.tready = reset_n & ready;
  assign fire         = saxis.tvalid & ready;

  assign txd  = txd_q;
  assign busy = busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            shift_q <= saxis.tdata;
            baud_q  <= '0;
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q  <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              // txd is registered, so present the bit that the shift is about to expose.
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q  <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (fire) begin
                shift_q <= saxis.tdata;
                state_q <= START;
                txd_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_axis.sv
// Directed bench for uart_tx_axis: reset, single frame, back-to-back, backpressure,
// mid-frame reset, and a 2/7/2 parameter variant on a second instance.
module tb_uart_tx_axis;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic txd_a, busy_a, txd_b, busy_b;
  int   n_chk = 0;
  int   n_fail = 0;

  uart_tx_axis_if #(.DATA_BITS(8)) sa ();
  uart_tx_axis_if #(.DATA_BITS(7)) sb ();

  uart_tx_axis #(.BAUD_DIVIDER(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .saxis(sa), .txd(txd_a), .busy(busy_a));
  uart_tx_axis #(.BAUD_DIVIDER(2), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .saxis(sb), .txd(txd_b), .busy(busy_b));

  always #5 clock = ~clock;

  // Expected line level in cycle c (0 = first start-bit cycle) of a frame.
  function automatic logic exp_txd(input logic [8:0] word, input int c, input int b, input int db);
    int bn;
    bn = c / b;
    if (bn == 0) return 1'b0;
    if (bn <= db) return word[bn-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; sa.tvalid = 1'b1; sa.tdata = 8'h5A;
    repeat (5) begin
      @(negedge clock);
      n_chk++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd_a); end
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
      n_chk++; if (sa.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b want 0", sa.tready); end
    end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    n_chk++; if (sa.tready !== 1'b1) begin n_fail++; $display("FAIL release_tready got %b want 1", sa.tready); end
    @(posedge clock); #1 sa.tvalid = 1'b0; sa.tdata = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h05A, c, 4, 8)) begin n_fail++; $display("FAIL release_frame c=%0d got %b want %b", c, txd_a, exp_txd(9'h05A, c, 4, 8)); end
    end
    @(negedge clock);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL release_idle_busy got %b want 0", busy_a); end
  endtask

  task automatic test_single();
    @(posedge clock); #1 sa.tvalid = 1'b1; sa.tdata = 8'h55;
    @(negedge clock);
    n_chk++; if (sa.tready !== 1'b1) begin n_fail++; $display("FAIL single_zero_latency got %b want 1", sa.tready); end
    @(posedge clock); #1 sa.tvalid = 1'b0; sa.tdata = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h055, c, 4, 8)) begin n_fail++; $display("FAIL single_txd c=%0d got %b want %b", c, txd_a, exp_txd(9'h055, c, 4, 8)); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy c=%0d got %b want 1", c, busy_a); end
      n_chk++; if (sa.tready !== (c == 39)) begin n_fail++; $display("FAIL single_tready c=%0d got %b want %b", c, sa.tready, (c == 39)); end
    end
    @(negedge clock);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy_a); end
    n_chk++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL single_txd_idle got %b want 1", txd_a); end
    n_chk++; if (sa.tready !== 1'b1) begin n_fail++; $display("FAIL single_tready_idle got %b want 1", sa.tready); end
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1 sa.tvalid = 1'b1; sa.tdata = 8'hA5;
    @(posedge clock); #1 sa.tdata = 8'h3C;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h0A5, c, 4, 8)) begin n_fail++; $display("FAIL b2b_first c=%0d got %b want %b", c, txd_a, exp_txd(9'h0A5, c, 4, 8)); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1 c=%0d got %b want 1", c, busy_a); end
      n_chk++; if (sa.tready !== (c == 39)) begin n_fail++; $display("FAIL b2b_tready c=%0d got %b want %b", c, sa.tready, (c == 39)); end
    end
    @(posedge clock); #1 sa.tvalid = 1'b0; sa.tdata = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h03C, c, 4, 8)) begin n_fail++; $display("FAIL b2b_second c=%0d got %b want %b", c, txd_a, exp_txd(9'h03C, c, 4, 8)); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2 c=%0d got %b want 1", c, busy_a); end
    end
    @(negedge clock);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy_a); end
  endtask

  task automatic test_backpressure();
    @(posedge clock); #1 sa.tvalid = 1'b1; sa.tdata = 8'h22;
    @(posedge clock); #1 sa.tvalid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h022, c, 4, 8)) begin n_fail++; $display("FAIL bp_first c=%0d got %b want %b", c, txd_a, exp_txd(9'h022, c, 4, 8)); end
      if (c >= 9) begin
        n_chk++; if (sa.tready !== (c == 39)) begin n_fail++; $display("FAIL bp_tready c=%0d got %b want %b", c, sa.tready, (c == 39)); end
        // word walks 0x11, 0x12, ... ; the edge after c=39 sees 0x2F
        sa.tvalid = 1'b1; sa.tdata = 8'(8'h11 + c - 9);
      end
    end
    @(posedge clock); #1 sa.tvalid = 1'b0; sa.tdata = 8'hEE;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h02F, c, 4, 8)) begin n_fail++; $display("FAIL bp_second c=%0d got %b want %b", c, txd_a, exp_txd(9'h02F, c, 4, 8)); end
    end
    repeat (3) begin
      @(negedge clock);
      n_chk++; if (busy_a !== 1'b0 || txd_a !== 1'b1) begin n_fail++; $display("FAIL bp_no_dup busy=%b txd=%b want busy 0 txd 1", busy_a, txd_a); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1 sa.tvalid = 1'b1; sa.tdata = 8'h00;
    @(posedge clock); #1 sa.tvalid = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h000, c, 4, 8)) begin n_fail++; $display("FAIL mid_frame c=%0d got %b want %b", c, txd_a, exp_txd(9'h000, c, 4, 8)); end
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL mid_txd got %b want 1", txd_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy_a); end
    n_chk++; if (sa.tready !== 1'b0) begin n_fail++; $display("FAIL mid_tready got %b want 0", sa.tready); end
    @(posedge clock); @(posedge clock); #1 reset_n = 1'b1; sa.tvalid = 1'b1; sa.tdata = 8'hFF;
    @(negedge clock);
    n_chk++; if (sa.tready !== 1'b1) begin n_fail++; $display("FAIL mid_release_tready got %b want 1", sa.tready); end
    @(posedge clock); #1 sa.tvalid = 1'b0; sa.tdata = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_chk++; if (txd_a !== exp_txd(9'h0FF, c, 4, 8)) begin n_fail++; $display("FAIL mid_newword c=%0d got %b want %b", c, txd_a, exp_txd(9'h0FF, c, 4, 8)); end
    end
    @(negedge clock);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy_end got %b want 0", busy_a); end
  endtask

  task automatic test_param();
    @(posedge clock); #1 sb.tvalid = 1'b1; sb.tdata = 7'h7F;
    @(negedge clock);
    n_chk++; if (sb.tready !== 1'b1) begin n_fail++; $display("FAIL param_tready got %b want 1", sb.tready); end
    @(posedge clock); #1 sb.tdata = 7'h05;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_chk++; if (txd_b !== exp_txd(9'h07F, c, 2, 7)) begin n_fail++; $display("FAIL param_first c=%0d got %b want %b", c, txd_b, exp_txd(9'h07F, c, 2, 7)); end
      n_chk++; if (sb.tready !== (c == 19)) begin n_fail++; $display("FAIL param_handshake c=%0d got %b want %b", c, sb.tready, (c == 19)); end
      n_chk++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL param_busy c=%0d got %b want 1", c, busy_b); end
    end
    @(posedge clock); #1 sb.tvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_chk++; if (txd_b !== exp_txd(9'h005, c, 2, 7)) begin n_fail++; $display("FAIL param_second c=%0d got %b want %b", c, txd_b, exp_txd(9'h005, c, 2, 7)); end
    end
    @(negedge clock);
    n_chk++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL param_busy_end got %b want 0", busy_b); end
  endtask

  initial begin
    sa.tvalid = 1'b0; sa.tdata = '0;
    sb.tvalid = 1'b0; sb.tdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
